register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised successor to the single-write, dual-read CPU register file for the KGP-miniRISC datapath.
- Generalised in data width, depth and read-port count.
- Adds a second write port with fixed priority, an optional hardwired-zero register, and a sequenced bulk-clear engine driven by a state machine.
- Sits between decode (read addresses) and writeback (ALU result plus load data) in the core.

Parameters:
- DATA_WIDTH, 32: bits per register.
- ADDR_WIDTH, 5: address bits; DEPTH = 2**ADDR_WIDTH registers.
- NUM_READ, 2: number of asynchronous read ports (1..4).
- ZERO_REG, 1: 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (acts only on a clk rising edge while 0).
- readReg  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- readData  out  NUM_READ*DATA_WIDTH  packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH].
- writeReg_0  in  ADDR_WIDTH  write port 0 address.
- writeData_0  in  DATA_WIDTH  write port 0 data.
- control_RegWrite_0  in  1  write port 0 enable.
- writeReg_1  in  ADDR_WIDTH  write port 1 address.
- writeData_1  in  DATA_WIDTH  write port 1 data.
- control_RegWrite_1  in  1  write port 1 enable.
- clr_start  in  1  request a bulk clear (sampled in IDLE only).
- clr_busy  out  1  high while the clear engine runs; write ports are blocked.
- clr_done  out  1  one-cycle pulse on the final clear cycle.

Behaviour:
- Reset (rst==0 at a clk edge):
  - All DEPTH registers are set to 0.
  - FSM goes to IDLE, clear counter goes to 0.
  - clr_busy=0, clr_done=0.
  - Reset takes precedence over writes, clr_start, and an in-progress clear (the clear is aborted).
- Reads:
  - Combinational.
  - readData[k] = mem[readReg[k]] as of the current cycle.
  - With ZERO_REG=1, address 0 always reads 0.
- Writes:
  - Occur on the rising edge when control_RegWrite_n==1, rst==1 and the FSM is IDLE.
  - Data is visible on reads in the cycle after the edge.
  - Both ports targeting the same address: port 1 wins and port 0's write is dropped.
  - Writes to address 0 are discarded when ZERO_REG=1.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on an edge with clr_start=1 (and rst=1); counter=0; clr_busy goes high the next cycle.
  - In CLEAR, each edge writes 0 to mem[counter] and increments the counter, giving exactly DEPTH cycles.
  - The counter is ADDR_WIDTH bits wide. On the cycle where counter==DEPTH-1, clr_done=1, and the next edge returns to IDLE with the counter wrapped to 0 and clr_busy=0.
  - clr_start in CLEAR is ignored; there is no restart.
  - clr_start asserted together with a write in IDLE: the write commits on that edge, then the clear starts.
  - Write enables in CLEAR are ignored (dropped, not queued). Upstream stalls on clr_busy.
  - Reads in CLEAR return current contents: already-swept registers read 0, the rest hold their old values.
- Widths: no arithmetic on data. Only the counter wraps, modulo DEPTH.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle write data when its address matches an enabled write address (nonzero when ZERO_REG=1), with port 1 priority.
  - Forwarding is suppressed while clr_busy=1 or rst=0.
  - Read-after-write within one cycle therefore returns the new value.
- Undefined: reads return the pre-edge stored value. Writeback-to-decode hazards are handled by pipeline stalls.

Test Plan:
- Reset: rst=0 for 2 edges, then rst=1; read addresses 5 and 8 -> readData=0,0; clr_busy=0.
- Basic write: port 0 writes 1298 to r8 and 5111 to r5 on consecutive edges; readReg={8,5} -> 1298, 5111 after the edges.
- Write collision: port 0 writes 455 and port 1 writes 8649130, both to r17 on the same edge -> r17 reads 8649130.
- Zero register (ZERO_REG=1): write 45611 to r0 -> r0 reads 0. With ZERO_REG=0, the same write -> r0 reads 45611.
- Bulk clear:
  - Preload r1=7 and r31=9, pulse clr_start.
  - clr_busy is high for 32 cycles; clr_done pulses once, on the cycle counter==31.
  - A write of 9876 to r17 issued mid-clear is dropped.
  - Afterwards every register reads 0.
- Reset during clear, plus bypass:
  - rst=0 at cycle 10 of a clear -> clr_busy=0 the next cycle and all registers read 0.
  - With REGFILE_BYPASS_EN, writing 42 to r3 while reading r3 -> readData=42 in the same cycle.
  - Without the macro -> the old value in that cycle and 42 in the next.

Source files
------------

// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-read, dual-write register file with a
// sequenced bulk-clear engine. Reads are combinational; port 1 wins over
// port 0 when both write the same address. Register 0 can be hardwired to
// zero through ZERO_REG. Write ports are blocked while the clear engine sweeps.
// Optional build macro: REGFILE_BYPASS_EN (forward same-cycle write data to
// matching read ports).
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0] readData,
  input  logic [ADDR_WIDTH-1:0]          writeReg_0,
  input  logic [DATA_WIDTH-1:0]          writeData_0,
  input  logic                           control_RegWrite_0,
  input  logic [ADDR_WIDTH-1:0]          writeReg_1,
  input  logic [DATA_WIDTH-1:0]          writeData_1,
  input  logic                           control_RegWrite_1,
  input  logic                           clr_start,
  output logic                           clr_busy,
  output logic                           clr_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0]   mem_reg [DEPTH];

  logic is_idle;
  logic we0;
  logic we1;

  assign is_idle = (state_reg == IDLE);

  // A write is effective only in IDLE and never to a hardwired-zero register 0.
  assign we0 = control_RegWrite_0 && is_idle && ((ZERO_REG == 0) || (writeReg_0 != '0));
  assign we1 = control_RegWrite_1 && is_idle && ((ZERO_REG == 0) || (writeReg_1 != '0));

`ifdef REGFILE_BYPASS_EN
  logic fwd0;
  logic fwd1;
  // Forwarding reuses the effective enables, so it is already off during a clear.
  assign fwd0 = we0 && rst;
  assign fwd1 = we1 && rst;
`endif

  // Clear-engine state and sweep counter; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: IDLE waits for clr_start, CLEAR sweeps DEPTH addresses once.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clr_busy   = 1'b0;
    clr_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (clr_start) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == {ADDR_WIDTH{1'b1}}) begin
          clr_done   = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  // Storage update: reset zeroes all, a sweep zeroes one entry, else the write
  // ports commit with port 1 last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (state_reg == CLEAR) begin
      mem_reg[cnt_reg] <= '0;
    end else begin
      if (we0) begin
        mem_reg[writeReg_0] <= writeData_0;
      end
      if (we1) begin
        mem_reg[writeReg_1] <= writeData_1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;

    assign raddr = readReg[gi*ADDR_WIDTH +: ADDR_WIDTH];

    // Combinational read with hardwired zero and optional write forwarding.
    always_comb begin
      rdata = mem_reg[raddr];
      if ((ZERO_REG != 0) && (raddr == '0)) begin
        rdata = '0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (fwd1 && (raddr == writeReg_1)) begin
        rdata = writeData_1;
      end else if (fwd0 && (raddr == writeReg_0)) begin
        rdata = writeData_0;
      end
`endif
    end

    assign readData[gi*DATA_WIDTH +: DATA_WIDTH] = rdata;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed test of register_file_mp with a behavioural
// model checked every cycle, plus hand-computed literal expectations.
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic           clk;
  logic           rst;
  logic [AW-1:0]  ra0, ra1;
  logic [NR*AW-1:0] readReg;
  logic [NR*DW-1:0] readData, readData_z0;
  logic [AW-1:0]  wa0, wa1;
  logic [DW-1:0]  wd0, wd1;
  logic           we0, we1;
  logic           clr_start;
  logic           clr_busy, clr_done, clr_busy_z0, clr_done_z0;

  assign readReg = {ra1, ra0};

  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .readReg(readReg), .readData(readData),
    .writeReg_0(wa0), .writeData_0(wd0), .control_RegWrite_0(we0),
    .writeReg_1(wa1), .writeData_1(wd1), .control_RegWrite_1(we1),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(0)) dut_z0 (
    .clk(clk), .rst(rst), .readReg(readReg), .readData(readData_z0),
    .writeReg_0(wa0), .writeData_0(wd0), .control_RegWrite_0(we0),
    .writeReg_1(wa1), .writeData_1(wd1), .control_RegWrite_1(we1),
    .clr_start(clr_start), .clr_busy(clr_busy_z0), .clr_done(clr_done_z0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 0;

  // ---------------- behavioural model ----------------
  // Register contents as plain integers; a clear is described by the interval
  // index in which clr_start was accepted: busy for the next DEPTH intervals,
  // and the d-th busy interval zeroes register d-1 at its closing edge.
  logic [DW-1:0] m_mem [DEPTH];
  int cyc = 0;
  int clr_s = -1000;

  function automatic int clear_offset();
    return cyc - clr_s;
  endfunction

  function automatic bit m_busy();
    return clear_offset() >= 1 && clear_offset() <= DEPTH;
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input bit zero);
    logic [DW-1:0] v;
    v = m_mem[a];
    if (zero && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (rst && !m_busy()) begin
      if (we1 && a == wa1 && (a != 0 || !zero)) return wd1;
      if (we0 && a == wa0 && (a != 0 || !zero)) return wd0;
    end
`endif
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      clr_s = -1000;
    end else if (m_busy()) begin
      m_mem[clear_offset() - 1] = '0;
    end else begin
      if (we0) m_mem[wa0] = wd0;
      if (we1) m_mem[wa1] = wd1;
      if (clr_start) clr_s = cyc;
    end
    cyc = cyc + 1;
  end

  task automatic cmp(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    else passes++;
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("model rd0",    readData[0 +: DW],     m_read(ra0, 1'b1));
      cmp("model rd1",    readData[DW +: DW],    m_read(ra1, 1'b1));
      cmp("model z0 rd0", readData_z0[0 +: DW],  m_read(ra0, 1'b0));
      cmp("model z0 rd1", readData_z0[DW +: DW], m_read(ra1, 1'b0));
      cmp("model busy",   {31'd0, clr_busy},     {31'd0, m_busy()});
      cmp("model done",   {31'd0, clr_done},     {31'd0, (m_busy() && clear_offset() == DEPTH)});
      cmp("model z0 busy", {31'd0, clr_busy_z0}, {31'd0, m_busy()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      ra0 = a[AW-1:0];
      ra1 = a[AW-1:0];
      @(negedge clk);
      cmp(name, readData[0 +: DW], 0);
      cmp(name, readData_z0[DW +: DW], 0);
      tick();
    end
  endtask

  int busy_cnt, done_cnt, done_at;

  initial begin
    rst = 0; ra0 = 0; ra1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
    we0 = 0; we1 = 0; clr_start = 0;

    // Reset: two edges low
    tick();
    cmp_en = 1;
    tick();
    rst = 1;
    ra1 = 8; ra0 = 5;
    @(negedge clk);
    $display("reset released, read r8/r5");
    cmp("reset r5", readData[0 +: DW], 0);
    cmp("reset r8", readData[DW +: DW], 0);
    cmp("reset busy", {31'd0, clr_busy}, 0);

    // Basic writes on consecutive edges
    we0 = 1; wa0 = 8; wd0 = 1298;
    tick();
    $display("write r8 <= 1298");
    wa0 = 5; wd0 = 5111;
    tick();
    $display("write r5 <= 5111");
    we0 = 0;
    @(negedge clk);
    cmp("basic r8", readData[DW +: DW], 1298);
    cmp("basic r5", readData[0 +: DW], 5111);

    // Collision: port 1 wins
    we0 = 1; wa0 = 17; wd0 = 455;
    we1 = 1; wa1 = 17; wd1 = 8649130;
    tick();
    $display("collision r17 <= 455 / 8649130");
    we0 = 0; we1 = 0; ra0 = 17;
    @(negedge clk);
    cmp("collision r17", readData[0 +: DW], 8649130);

    // Zero register
    we0 = 1; wa0 = 0; wd0 = 45611;
    tick();
    $display("write r0 <= 45611");
    we0 = 0; ra0 = 0;
    @(negedge clk);
    cmp("zero r0 ZERO_REG=1", readData[0 +: DW], 0);
    cmp("zero r0 ZERO_REG=0", readData_z0[0 +: DW], 45611);

    // Bulk clear
    we0 = 1; wa0 = 1; wd0 = 7;
    we1 = 1; wa1 = 31; wd1 = 9;
    tick();
    $display("preload r1 <= 7, r31 <= 9");
    we0 = 0; we1 = 0;
    ra0 = 1; ra1 = 31;
    clr_start = 1;
    tick();
    $display("clear started");
    clr_start = 0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (clr_busy) busy_cnt++;
      if (clr_done) begin done_cnt++; done_at = i; end
      clr_start = (i == 5);
      we0 = (i == 20); wa0 = 17; wd0 = 9876;
      tick();
    end
    we0 = 0; clr_start = 0;
    $display("clear finished: busy=%0d done=%0d at %0d", busy_cnt, done_cnt, done_at);
    cmp("clear busy cycles", busy_cnt, 32);
    cmp("clear done pulses", done_cnt, 1);
    cmp("clear done position", done_at, 31);
    all_zero("after clear");

    // Write together with clr_start, then reset mid-clear
    we0 = 1; wa0 = 20; wd0 = 55;
    tick();
    we0 = 1; wa0 = 3; wd0 = 77; clr_start = 1;
    tick();
    $display("write r3 <= 77 with clear start");
    we0 = 0; clr_start = 0; ra0 = 3; ra1 = 20;
    @(negedge clk);
    cmp("write with start r3", readData[0 +: DW], 77);
    cmp("busy after start", {31'd0, clr_busy}, 1);
    for (int i = 1; i < 10; i++) tick();
    rst = 0;
    tick();
    $display("reset during clear");
    rst = 1;
    @(negedge clk);
    cmp("busy after abort", {31'd0, clr_busy}, 0);
    all_zero("after abort");

    // Read-after-write in the same cycle
    we0 = 1; wa0 = 3; wd0 = 11;
    tick();
    wd0 = 42; ra0 = 3;
    @(negedge clk);
    $display("write r3 <= 42 while reading r3");
`ifdef REGFILE_BYPASS_EN
    cmp("raw same cycle", readData[0 +: DW], 42);
`else
    cmp("raw same cycle", readData[0 +: DW], 11);
`endif
    tick();
    we0 = 0;
    @(negedge clk);
    cmp("raw next cycle", readData[0 +: DW], 42);

    tick();
    cmp_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
